mips_mem: RTL and testbench
===========================

# mips_mem

Unified instruction/data memory responder for the multicycle `mips` core. It serves the core's instruction-fetch port and its single data port from one word-organised RAM that covers the program and stack window. After reset it runs a zero-fill sweep, then answers reads with one cycle of latency and commits writes on the clock edge. It also records the first illegal access for the bench and for debug. Port names match the core's ports so the two connect name-for-name.

## Interface
Parameters:
- `BASE_ADDR`, 32'h80000000. Byte address of word 0.
- `ADDR_BITS`, 19. log2 of the depth in words. The default window is 0x80000000–0x801FFFFF, which covers `pc_init` 0x80020000 and `sp_init` 0x80120000.

Ports:
- `clk` in 1. Single clock; all state changes on posedge.
- `reset` in 1. Synchronous, active-high.
- `instr_addr` in 32. Fetch byte address.
- `instr_in` out 32. Fetch data, registered.
- `data_addr` in 32. Data byte address.
- `data_out` in 32. Write data from the core.
- `data_rd_wr` in 1. 1 = read, 0 = write.
- `data_in` out 32. Read data, registered.
- `busy` out 1. High during the zero-fill sweep.
- `err` out 1. Sticky illegal-access flag.
- `err_addr` out 32. Byte address of the first illegal access.

## Operation
- Storage: 2^ADDR_BITS × 32-bit words.
  - Word index = (addr − BASE_ADDR)[ADDR_BITS+1:2].
  - In range ⇔ BASE_ADDR ≤ addr < BASE_ADDR + 4·2^ADDR_BITS. Compute the range check in 33-bit arithmetic so there is no wrap at 0xFFFFFFFF.
  - Aligned ⇔ addr[1:0] == 0.
- State machine, two states:
  - INIT:
    - `busy`=1.
    - Counter `fill_ptr` writes 0 into word `fill_ptr` each cycle, then increments.
    - When `fill_ptr` == 2^ADDR_BITS−1, that word is written and the next state is RUN.
    - Core reads return 0. Core writes are dropped.
    - No error checking.
  - RUN:
    - `busy`=0.
    - Fetch: `instr_in` ← mem[idx(instr_addr)] if the access is legal, else 0.
    - Data read (`data_rd_wr`=1): `data_in` ← mem[idx(data_addr)] if legal, else 0.
    - Data write (`data_rd_wr`=0): mem[idx(data_addr)] ← `data_out` if legal, else the write is dropped.
    - A write repeated over consecutive cycles with the same address and data is idempotent. This is required because the core holds `data_rd_wr` low across stages.
    - During a write cycle `data_in` holds its previous value.
- Illegal access: out of range or misaligned, on the fetch port or the data port, in RUN only.
  - The first illegal access sets `err`=1 and captures the offending byte address in `err_addr`.
  - If fetch and data are both illegal in the same cycle, the data address is captured.
  - Later errors do not overwrite `err_addr`.
  - `err` clears only on reset.
- Fetch and data accesses to the same word in the same cycle, where the data access is a write: `instr_in` returns the old word (read-before-write). The new word is visible from the next cycle.

## Timing
- `reset` high at a posedge forces the following:
  - state=INIT, `fill_ptr`=0.
  - `instr_in`=0, `data_in`=0, `busy`=1, `err`=0, `err_addr`=0.
  - While `reset` stays high, the state is held in INIT with `fill_ptr`=0.
- The sweep starts on the first posedge with `reset` low and takes exactly 2^ADDR_BITS cycles.
  - `busy` falls on the edge that writes the last word.
  - The first core access is serviced on the next edge.
- Reset asserted mid-sweep or in RUN: the sweep restarts from word 0, the whole array is re-zeroed, and the error state clears.
- Read latency is 1 cycle. An address presented before edge N gives data on the outputs after edge N. The outputs hold until the next read on the same port.
- Write latency is 0 cycles to the array. A read of the same address on the following edge returns the new data.
- `err`/`err_addr` update on the edge where the illegal access is sampled.

## Test plan
- Reset/sweep (ADDR_BITS=4), with the array preloaded with 0xDEADBEEF:
  - reset 1 cycle → `busy`=1 for exactly 16 cycles.
  - Then reads of every address 0x80000000..0x8000003C return 0.
  - `err`=0 throughout.
- Write/read:
  - In RUN, write 0x12345678 to 0x80000008 → a data read of 0x80000008 returns 0x12345678 one cycle later.
  - A fetch of 0x80000008 also returns 0x12345678.
- Same-word collision:
  - Word 0x80000004 holds 0xAAAA0000.
  - Write 0x5555FFFF to it while fetching the same address → `instr_in`=0xAAAA0000 that cycle.
  - The next fetch returns 0x5555FFFF.
- Illegal access:
  - Data read of 0x80000042 (ADDR_BITS=4) → `data_in`=0, `err`=1, `err_addr`=0x80000042.
  - A later fetch of 0x7FFFFFFC leaves `err_addr` unchanged.
  - A write to 0x80000040 is dropped and no word changes.
- Reset mid-operation:
  - After writing 0xCAFEF00D to 0x80000000 and setting `err`, assert reset during RUN.
  - → `err`=0, `err_addr`=0, `busy`=1 for 16 cycles.
  - Then 0x80000000 reads 0.
- Writes during INIT:
  - Writes issued while `busy`=1 → dropped.
  - All words read 0 after the sweep.

Source files
------------

// File: rtl/mips_mem.sv
// mips_mem: unified fetch/data word RAM for the multicycle mips core, with zero-fill after reset and sticky illegal-access capture.
module mips_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter int ADDR_BITS = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_rd_wr,
  output logic [31:0] data_in,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr
);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [32:0] SPAN = 33'd4 << ADDR_BITS;
  logic [0:0] state;
  logic [ADDR_BITS-1:0] fill_ptr;
  logic [31:0] mem [0:(1<<ADDR_BITS)-1];
  logic [32:0] i_off, d_off;
  logic i_ok, d_ok, we;
  logic [ADDR_BITS-1:0] wa;
  logic [31:0] wd;
  // 33-bit offsets: addresses below BASE_ADDR wrap to huge values and fail the span test
  always_comb begin
    i_off = {1'b0, instr_addr} - {1'b0, BASE_ADDR};
    d_off = {1'b0, data_addr} - {1'b0, BASE_ADDR};
    i_ok = i_off < SPAN && instr_addr[1:0] == 2'b00;
    d_ok = d_off < SPAN && data_addr[1:0] == 2'b00;
    we = !reset && (state == INIT || (d_ok && !data_rd_wr));
    wa = state == INIT ? fill_ptr : d_off[ADDR_BITS+1:2];
    wd = state == INIT ? '0 : data_out;
  end
  assign busy = state == INIT;
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      fill_ptr <= '0;
      instr_in <= '0;
      data_in <= '0;
      err <= 1'b0;
      err_addr <= '0;
    end else if (state == INIT) begin
      fill_ptr <= fill_ptr + 1'b1;
      if (&fill_ptr) state <= RUN;
    end else begin
      instr_in <= i_ok ? mem[i_off[ADDR_BITS+1:2]] : '0;
      if (data_rd_wr) data_in <= d_ok ? mem[d_off[ADDR_BITS+1:2]] : '0;
      if (!err && !(i_ok && d_ok)) begin
        err <= 1'b1;
        err_addr <= d_ok ? instr_addr : data_addr;
      end
    end
  end
endmodule

// File: tb/tb_mips_mem.sv
// tb_mips_mem: scoreboard bench for mips_mem with a 16-word array.
module tb_mips_mem;
  localparam logic [31:0] B = 32'h80000000;
  logic clk = 1'b0, reset = 1'b1, data_rd_wr = 1'b1;
  logic [31:0] instr_addr = B, data_addr = B, data_out = '0;
  logic [31:0] instr_in, data_in, err_addr;
  logic busy, err;
  mips_mem #(.BASE_ADDR(B), .ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_in(instr_in),
    .data_addr(data_addr), .data_out(data_out), .data_rd_wr(data_rd_wr),
    .data_in(data_in), .busy(busy), .err(err), .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [16];
  logic [31:0] m_d, m_ea;
  logic m_err;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [31:0] a);
    return a >= B && a < B + 32'h40 && a[1:0] == 2'b00;
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - B) >> 2);
  endfunction
  function automatic logic [31:0] pick(input int s);
    return s == 0 ? instr_in : s == 1 ? data_in : s == 2 ? {31'b0, err} : err_addr;
  endfunction
  task automatic op(input string tag, input logic [31:0] ia, input logic [31:0] da,
                    input logic [31:0] dout, input logic rw);
    exp_t e;
    instr_addr = ia;
    data_addr = da;
    data_out = dout;
    data_rd_wr = rw;
    sb.push_back('{tag, 0, legal(ia) ? mdl[widx(ia)] : 32'h0});
    if (rw) m_d = legal(da) ? mdl[widx(da)] : 32'h0;
    sb.push_back('{tag, 1, m_d});
    if (!m_err && !(legal(ia) && legal(da))) begin
      m_err = 1'b1;
      m_ea = legal(da) ? ia : da;
    end
    sb.push_back('{tag, 2, {31'b0, m_err}});
    sb.push_back('{tag, 3, m_ea});
    if (!rw && legal(da)) mdl[widx(da)] = dout;
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s.%0d", e.tag, e.sel), pick(e.sel), e.exp);
    end
  endtask
  task automatic sweep(input bit wr);
    int n;
    reset = 1'b1;
    data_rd_wr = 1'b1;
    instr_addr = B;
    data_addr = B;
    @(posedge clk); #1;
    check("rst.busy", {31'b0, busy}, 32'd1);
    check("rst.err", {31'b0, err}, 32'd0);
    check("rst.err_addr", err_addr, 32'd0);
    check("rst.instr", instr_in, 32'd0);
    check("rst.data", data_in, 32'd0);
    reset = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
    m_d = '0;
    m_err = 1'b0;
    m_ea = '0;
    if (wr) begin
      data_rd_wr = 1'b0;
      data_out = 32'h11111111;
      instr_addr = B + 32'h41;
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      data_addr = B + 32'((n % 16) * 4);
      @(posedge clk); #1;
      n++;
      check("sweep.err", {31'b0, err}, 32'd0);
      check("sweep.data", data_in, 32'd0);
    end
    check("sweep.len", n, 32'd16);
  endtask
  task automatic readall(input string tag);
    for (int i = 0; i < 16; i++) op(tag, B + 32'(i * 4), B + 32'(i * 4), 32'h0, 1'b1);
  endtask
  initial begin
    sweep(1'b1);
    readall("init_wr_drop");
    for (int i = 0; i < 16; i++) op("fill", B, B + 32'(i * 4), 32'hDEADBEEF, 1'b0);
    op("fill_rb", B + 32'h3C, B + 32'hC, 32'h0, 1'b1);
    sweep(1'b0);
    readall("rezero");
    op("wr", B, B + 32'h8, 32'h12345678, 1'b0);
    op("rd", B, B + 32'h8, 32'h0, 1'b1);
    op("fetch", B + 32'h8, B, 32'h0, 1'b1);
    op("pre", B, B + 32'h4, 32'hAAAA0000, 1'b0);
    op("coll", B + 32'h4, B + 32'h4, 32'h5555FFFF, 1'b0);
    op("coll_next", B + 32'h4, B, 32'h0, 1'b1);
    op("rep", B, B + 32'hC, 32'h0BADF00D, 1'b0);
    op("rep", B, B + 32'hC, 32'h0BADF00D, 1'b0);
    op("rep_rd", B, B + 32'hC, 32'h0, 1'b1);
    op("ill_rd", B, B + 32'h42, 32'h0, 1'b1);
    op("ill_fetch", 32'h7FFFFFFC, B, 32'h0, 1'b1);
    op("wrap", 32'hFFFFFFFC, B + 32'h8, 32'h0, 1'b1);
    op("ill_wr", B, B + 32'h40, 32'hFFFFFFFF, 1'b0);
    readall("after_ill");
    sweep(1'b0);
    op("caf", B, B, 32'hCAFEF00D, 1'b0);
    op("caf_rd", B + 32'h4, B, 32'h0, 1'b1);
    op("both_ill", B + 32'h1, B + 32'h50, 32'h0, 1'b1);
    sweep(1'b0);
    op("post", B, B, 32'h0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
